// File: rtl/pio_handshake_out_pkg.sv
// Shared definitions for the pio_handshake_out slave: register map, STATUS
// bit positions, FSM state type and the byteenable expansion helper.
package pio_handshake_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  localparam int BUSY  = 0;
  localparam int OVF   = 1;
  localparam int TMO   = 2;
  localparam int IRQEN = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pio_handshake_out_timeout_counter.sv
// Down-counter used to abandon transfers: loads on launch, decrements while
// downstream is not ready, and saturates at zero.
module pio_timeout_counter #(
  parameter int               WIDTH      = 11,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pio_handshake_out.sv
// Avalon-MM output PIO: each accepted write to DATA/OUTSET/OUTCLEAR launches one
// valid/ready transfer on out_port; STATUS holds busy, sticky flags and irq_en.
module pio_handshake_out
  import pio_handshake_out_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] RESET_VALUE    = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  irq
);

  localparam logic                 TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t                state;
  logic                  ovf;
  logic                  tmo;
  logic                  irq_en;
  logic                  wr_en;
  logic                  status_wr;
  logic                  launch;
  logic                  complete;
  logic                  accept;
  logic                  drop;
  logic                  cnt_zero;
  logic                  timeout_hit;
  logic [31:0]           mask;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] next_data;

  // Valid/ready: a transfer is the cycle pair where out_valid is high and
  // out_ready is sampled high at the clock edge; out_port is held stable
  // from the launch edge until that completion edge or a timeout.
  assign wr_en       = chipselect & ~write_n;
  assign status_wr   = wr_en & (address == ADDR_STATUS) & byteenable[0];
  assign launch      = wr_en & (address != ADDR_STATUS);
  assign complete    = (state == SEND) & out_ready;
  assign accept      = launch & ((state == IDLE) | complete);
  assign drop        = launch & ~accept;
  assign timeout_hit = TMO_EN & (state == SEND) & ~out_ready & cnt_zero;

  assign mask  = byte_mask(byteenable);
  assign wmask = writedata[DATA_WIDTH-1:0] & mask[DATA_WIDTH-1:0];

  always_comb begin
    next_data = out_port;
    case (address)
      ADDR_DATA:     next_data = (out_port & ~mask[DATA_WIDTH-1:0]) | wmask;
      ADDR_OUTSET:   next_data = out_port | wmask;
      ADDR_OUTCLEAR: next_data = out_port & ~wmask;
      default:       next_data = out_port;
    endcase
  end

  pio_timeout_counter #(
    .WIDTH      (CNT_WIDTH),
    .LOAD_VALUE (TMO_LOAD)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .dec   ((state == SEND) & ~out_ready),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_port  <= RESET_VALUE[DATA_WIDTH-1:0];
    end else begin
      if (accept) begin
        out_port <= next_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          // A launch accepted on the completion edge keeps the port busy.
          if (accept) begin
            state     <= SEND;
            out_valid <= 1'b1;
          end else if (complete || timeout_hit) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf      <= 1'b0;
      tmo      <= 1'b0;
      irq_en   <= 1'b0;
      readdata <= '0;
    end else begin
      if (drop) begin
        ovf <= 1'b1;
      end else if (status_wr && writedata[OVF]) begin
        ovf <= 1'b0;
      end
      if (timeout_hit) begin
        tmo <= 1'b1;
      end else if (status_wr && writedata[TMO]) begin
        tmo <= 1'b0;
      end
      if (status_wr) begin
        irq_en <= writedata[IRQEN];
      end
      case (address)
        ADDR_DATA:   readdata <= 32'(out_port);
        ADDR_STATUS: readdata <= {28'd0, irq_en, tmo, ovf, (state == SEND)};
        default:     readdata <= '0;
      endcase
    end
  end

  assign irq = (ovf | tmo) & irq_en;

endmodule
